// File: rtl/timer_irq_source.sv
// Countdown timer that raises a CP0 HWInt request: pending appears PRESET+2 cycles after EN is set, and irq follows pending with no added latency.
// The single-cycle bridge port never stalls, and CPU writes are applied before the state machine acts on them in the same cycle.
module timer_irq_source #(
    parameter logic [31:0] PRESET_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state;
    logic        ctrlEn;
    logic [1:0]  ctrlMode;
    logic        ctrlIm;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic        wrCtrl;
    logic        wrPreset;
    logic        enW;
    logic [1:0]  modeW;
    logic        imW;
    logic [31:0] presetW;
    logic        autoReload;

    assign wrCtrl   = sel && we && (addr == ADDR_CTRL);
    assign wrPreset = sel && we && (addr == ADDR_PRESET);

    // Register values as seen after this cycle's CPU write; the FSM decides on these.
    assign enW        = wrCtrl   ? wdata[0]   : ctrlEn;
    assign modeW      = wrCtrl   ? wdata[2:1] : ctrlMode;
    assign imW        = wrCtrl   ? wdata[3]   : ctrlIm;
    assign presetW    = wrPreset ? wdata      : preset;
    assign autoReload = (modeW == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrlEn   <= 1'b0;
            ctrlMode <= 2'b00;
            ctrlIm   <= 1'b0;
            preset   <= PRESET_INIT;
            count    <= 32'h0;
            pending  <= 1'b0;
        end else begin
            ctrlEn   <= enW;
            ctrlMode <= modeW;
            ctrlIm   <= imW;
            preset   <= presetW;

            // Software acknowledge; the expiry set below overrides it when both land together.
            if (wrCtrl || wrPreset) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enW) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= presetW;
                    state <= CNT;
                end
                CNT: begin
                    if (!enW) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count   <= 32'h0;
                        pending <= 1'b1;
                        state   <= INT;
                    end
                end
                INT: begin
                    if (autoReload) begin
                        pending <= 1'b0;
                        state   <= LOAD;
                    end else begin
                        // A CTRL write in this cycle keeps its EN so software can re-arm.
                        if (!wrCtrl) begin
                            ctrlEn <= 1'b0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr)
            ADDR_CTRL:   rdata = {28'h0, ctrlIm, ctrlMode, ctrlEn};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = 32'h0;
        endcase
    end

    assign irq = ctrlIm & pending;

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source: per-cycle COUNT/irq expectations are queued with each stimulus and popped as cycles elapse.
module tb_timer_irq_source;

    localparam logic [31:0] PINIT = 32'h0000_00A5;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] count;
        logic        irq;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] t2Cnt [5];
    logic [31:0] t5Cnt [11];

    timer_irq_source #(.PRESET_INIT(PINIT)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        checkVal(tag, rdata, exp);
    endtask

    task automatic expectCyc(input string tag, input logic [31:0] cnt, input logic irqExp);
        exp_t e;
        e.tag   = tag;
        e.count = cnt;
        e.irq   = irqExp;
        expQ.push_back(e);
    endtask

    task automatic sampleCheck();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed no entry expected one queued");
        end else begin
            e = expQ.pop_front();
            addr = 2'd2;
            #1;
            checkVal({e.tag, "_count"}, rdata, e.count);
            checkVal({e.tag, "_irq"}, {31'h0, irq}, {31'h0, e.irq});
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            sampleCheck();
            tick();
        end
    endtask

    initial begin
        t2Cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        t5Cnt = '{32'd1, 32'd0, 32'd0, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'h0;
        reset = 1'b1;

        // Reset state
        doReset();
        readCheck("rst_ctrl", 2'd0, 32'h0);
        readCheck("rst_preset", 2'd1, PINIT);
        readCheck("rst_count", 2'd2, 32'h0);
        readCheck("rst_addr3", 2'd3, 32'h0);
        checkVal("rst_irq", {31'h0, irq}, 32'h0);

        // One-shot, PRESET=5: irq held until CTRL=0x8 acknowledges
        doReset();
        busWrite(2'd1, 32'd5);
        busWrite(2'd0, 32'h9);
        expectCyc("t1_c1", 32'd0, 1'b0);
        for (int k = 2; k <= 6; k++) expectCyc("t1_down", 32'(7 - k), 1'b0);
        expectCyc("t1_c7", 32'd0, 1'b1);
        runCycles(7);
        readCheck("t1_ctrl_en_clr", 2'd0, 32'h8);
        for (int k = 0; k < 3; k++) expectCyc("t1_held", 32'd0, 1'b1);
        runCycles(3);
        busWrite(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) expectCyc("t1_acked", 32'd0, 1'b0);
        runCycles(3);

        // Auto-reload, PRESET=3: period 5 with a single-cycle irq, four periods
        doReset();
        busWrite(2'd1, 32'd3);
        busWrite(2'd0, 32'hB);
        for (int c = 1; c <= 21; c++) expectCyc("t2", t2Cnt[(c + 3) % 5], ((c + 3) % 5) == 3);
        runCycles(21);

        // PRESET rewrite mid-period only affects the following period
        expectCyc("t5_pre", 32'd3, 1'b0);
        runCycles(1);
        expectCyc("t5_at2", 32'd2, 1'b0);
        sampleCheck();
        busWrite(2'd1, 32'd7);
        for (int k = 0; k < 11; k++) expectCyc("t5_reload", t5Cnt[k], (k == 1) || (k == 10));
        runCycles(11);
        busWrite(2'd0, 32'h0);
        expectCyc("t5_frozen", 32'd7, 1'b0);
        sampleCheck();
        busWrite(2'd2, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) expectCyc("t5_cnt_ro", 32'd7, 1'b0);
        runCycles(3);
        busWrite(2'd3, 32'h1234_5678);
        readCheck("t5_addr3", 2'd3, 32'h0);
        busWrite(2'd0, 32'hFFFF_FFF0);
        readCheck("t5_ctrl_hi", 2'd0, 32'h0);
        readCheck("t5_preset", 2'd1, 32'd7);

        // Masked expiry, then a CTRL write landing on the expiry edge and one in INT
        doReset();
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h1);
        expectCyc("t3_c1", 32'd0, 1'b0);
        expectCyc("t3_c2", 32'd2, 1'b0);
        runCycles(2);
        expectCyc("t3_c3", 32'd1, 1'b0);
        sampleCheck();
        busWrite(2'd0, 32'h9);
        expectCyc("t3_setwins", 32'd0, 1'b1);
        sampleCheck();
        busWrite(2'd0, 32'h9);
        readCheck("t3_rearm_ctrl", 2'd0, 32'h9);
        expectCyc("t3_clr", 32'd0, 1'b0);
        expectCyc("t3_load", 32'd0, 1'b0);
        expectCyc("t3_r2", 32'd2, 1'b0);
        expectCyc("t3_r1", 32'd1, 1'b0);
        expectCyc("t3_rirq", 32'd0, 1'b1);
        runCycles(5);

        // Clearing EN freezes COUNT; setting it again reloads
        doReset();
        busWrite(2'd1, 32'd10);
        busWrite(2'd0, 32'h9);
        expectCyc("t4_c1", 32'd0, 1'b0);
        for (int k = 2; k <= 5; k++) expectCyc("t4_down", 32'(12 - k), 1'b0);
        runCycles(5);
        expectCyc("t4_at6", 32'd6, 1'b0);
        sampleCheck();
        busWrite(2'd0, 32'h8);
        for (int k = 0; k < 20; k++) expectCyc("t4_hold", 32'd6, 1'b0);
        runCycles(20);
        busWrite(2'd0, 32'h9);
        expectCyc("t4_load", 32'd6, 1'b0);
        for (int k = 2; k <= 11; k++) expectCyc("t4_rerun", 32'(12 - k), 1'b0);
        expectCyc("t4_irq", 32'd0, 1'b1);
        runCycles(12);

        // Reset mid-count, then PRESET=0 behaves as 1, then reset while irq is high
        doReset();
        busWrite(2'd1, 32'd6);
        busWrite(2'd0, 32'h9);
        expectCyc("t6_c1", 32'd0, 1'b0);
        expectCyc("t6_c2", 32'd6, 1'b0);
        expectCyc("t6_c3", 32'd5, 1'b0);
        runCycles(3);
        expectCyc("t6_at4", 32'd4, 1'b0);
        sampleCheck();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        readCheck("t6_rst_ctrl", 2'd0, 32'h0);
        readCheck("t6_rst_preset", 2'd1, PINIT);
        readCheck("t6_rst_count", 2'd2, 32'h0);
        checkVal("t6_rst_irq", {31'h0, irq}, 32'h0);
        busWrite(2'd1, 32'd0);
        busWrite(2'd0, 32'h9);
        expectCyc("t6_z1", 32'd0, 1'b0);
        expectCyc("t6_z2", 32'd0, 1'b0);
        expectCyc("t6_z3", 32'd0, 1'b1);
        expectCyc("t6_z4", 32'd0, 1'b1);
        runCycles(3);
        sampleCheck();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkVal("t6_rst2_irq", {31'h0, irq}, 32'h0);
        readCheck("t6_rst2_ctrl", 2'd0, 32'h0);

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
